// File: rtl/rtsnoc_pkg.sv
// Shared definitions for the RTSNoC AXI4-Lite FIFO slave: register map,
// STATUS/CTRL bit positions, AXI response codes and header/bus width helpers.
package rtsnoc_pkg;

    // Register select, decoded from addr[4:2]; 6 and 7 are unmapped
    typedef enum logic [2:0] {
        REG_STATUS  = 3'd0,
        REG_CTRL    = 3'd1,
        REG_TX_HDR  = 3'd2,
        REG_TX_DATA = 3'd3,
        REG_RX_HDR  = 3'd4,
        REG_RX_DATA = 3'd5
    } reg_sel_e;

    localparam int ST_RX_EMPTY   = 0;
    localparam int ST_RX_FULL    = 1;
    localparam int ST_TX_EMPTY   = 2;
    localparam int ST_TX_FULL    = 3;
    localparam int ST_RX_CNT_LSB = 8;
    localparam int ST_TX_CNT_LSB = 16;

    localparam int CTRL_RX_INT_EN       = 0;
    localparam int CTRL_TX_EMPTY_INT_EN = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Full header: {orig_x, orig_y, orig_h, dst_x, dst_y, dst_h}
    function automatic int hdr_w(input int sx, input int sy);
        return 2 * sx + 2 * sy + 6;
    endfunction

    // Destination half of the header, as held in TX_HDR
    function automatic int dst_w(input int sx, input int sy);
        return sx + sy + 3;
    endfunction

    function automatic int bus_w(input int sx, input int sy, input int dw);
        return dw + hdr_w(sx, sy);
    endfunction

    function automatic logic [7:0] sat_count8(input logic [31:0] cnt);
        return (cnt > 32'd255) ? 8'hFF : cnt[7:0];
    endfunction

endpackage

// File: rtl/rtsnoc_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry one extra bit so
// full and empty are told apart. Push while full is accepted if a pop happens.
module rtsnoc_sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      din_i,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      dout_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   count_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [WIDTH-1:0]    mem_d [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
    logic                do_push, do_pop;

    assign count_o = wr_ptr_q - rd_ptr_q;
    assign full_o  = (count_o == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty_o = (count_o == '0);
    assign dout_o  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

    always_comb begin
        do_pop   = pop_i & ~empty_o;
        do_push  = push_i & (~full_o | do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[DEPTH_LOG2-1:0]] = din_i;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/rtsnoc_axi4lite_fifo_slave.sv
// AXI4-Lite slave bridging a CPU to one RTSNoC router port through TX/RX
// FIFOs, with a programmable destination header and a level interrupt.
module rtsnoc_axi4lite_fifo_slave
    import rtsnoc_pkg::*;
#(
    parameter int NOC_X          = 0,
    parameter int NOC_Y          = 0,
    parameter int NOC_LOCAL_ADR  = 0,
    parameter int SOC_SIZE_X     = 1,
    parameter int SOC_SIZE_Y     = 1,
    parameter int NOC_DATA_WIDTH = 32,
    parameter int TX_DEPTH_LOG2  = 2,
    parameter int RX_DEPTH_LOG2  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,

    input  logic [31:0]          axi_awaddr_i,
    input  logic                 axi_awvalid_i,
    output logic                 axi_awready_o,
    input  logic [31:0]          axi_wdata_i,
    input  logic [3:0]           axi_wstrb_i,
    input  logic                 axi_wvalid_i,
    output logic                 axi_wready_o,
    output logic [1:0]           axi_bresp_o,
    output logic                 axi_bvalid_o,
    input  logic                 axi_bready_i,
    input  logic [31:0]          axi_araddr_i,
    input  logic                 axi_arvalid_i,
    output logic                 axi_arready_o,
    output logic [31:0]          axi_rdata_o,
    output logic [1:0]           axi_rresp_o,
    output logic                 axi_rvalid_o,
    input  logic                 axi_rready_i,

    output logic [bus_w(SOC_SIZE_X, SOC_SIZE_Y, NOC_DATA_WIDTH)-1:0] noc_din_o,
    output logic                 noc_wr_o,
    input  logic                 noc_wait_i,
    input  logic [bus_w(SOC_SIZE_X, SOC_SIZE_Y, NOC_DATA_WIDTH)-1:0] noc_dout_i,
    input  logic                 noc_nd_i,
    output logic                 noc_rd_o,
    output logic                 noc_int_o
);

    localparam int DW    = NOC_DATA_WIDTH;
    localparam int DST_W = dst_w(SOC_SIZE_X, SOC_SIZE_Y);
    localparam int BUS_W = bus_w(SOC_SIZE_X, SOC_SIZE_Y, NOC_DATA_WIDTH);
    localparam int TXW   = DST_W + DW;

    localparam logic [SOC_SIZE_X-1:0] SRC_X = SOC_SIZE_X'(NOC_X);
    localparam logic [SOC_SIZE_Y-1:0] SRC_Y = SOC_SIZE_Y'(NOC_Y);
    localparam logic [2:0]            SRC_H = 3'(NOC_LOCAL_ADR);

    logic              aw_rdy_q, aw_rdy_d;
    logic              ar_rdy_q, ar_rdy_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              rvalid_q, rvalid_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        ctrl_q, ctrl_d;
    logic [DST_W-1:0]  tx_hdr_q, tx_hdr_d;
    logic              irq_q, irq_d;

    logic                   tx_push, tx_pop, tx_full, tx_empty;
    logic [TX_DEPTH_LOG2:0] tx_count;
    logic [TXW-1:0]         tx_din, tx_head;
    logic                   rx_push, rx_pop, rx_full, rx_empty;
    logic [RX_DEPTH_LOG2:0] rx_count;
    logic [BUS_W-1:0]       rx_head;

    logic        wr_fire, rd_fire;
    logic [31:0] status;
    logic [31:0] strb_mask;
    logic        unused_bits;

    rtsnoc_sync_fifo #(
        .WIDTH      (TXW),
        .DEPTH_LOG2 (TX_DEPTH_LOG2)
    ) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (tx_push),
        .din_i   (tx_din),
        .pop_i   (tx_pop),
        .dout_o  (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count)
    );

    rtsnoc_sync_fifo #(
        .WIDTH      (BUS_W),
        .DEPTH_LOG2 (RX_DEPTH_LOG2)
    ) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (rx_push),
        .din_i   (noc_dout_i),
        .pop_i   (rx_pop),
        .dout_o  (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_count)
    );

    assign tx_din    = {tx_hdr_q, axi_wdata_i[DW-1:0]};
    assign noc_wr_o  = ~tx_empty;
    assign noc_din_o = {SRC_X, SRC_Y, SRC_H, tx_head};
    assign tx_pop    = noc_wr_o & ~noc_wait_i;
    assign noc_rd_o  = noc_nd_i & ~rx_full;
    assign rx_push   = noc_rd_o;

    assign axi_awready_o = aw_rdy_q;
    assign axi_wready_o  = aw_rdy_q;
    assign axi_bvalid_o  = bvalid_q;
    assign axi_bresp_o   = bresp_q;
    assign axi_arready_o = ar_rdy_q;
    assign axi_rvalid_o  = rvalid_q;
    assign axi_rresp_o   = rresp_q;
    assign axi_rdata_o   = rdata_q;
    assign noc_int_o     = irq_q;

    assign strb_mask = {{8{axi_wstrb_i[3]}}, {8{axi_wstrb_i[2]}},
                        {8{axi_wstrb_i[1]}}, {8{axi_wstrb_i[0]}}};
    assign unused_bits = ^{axi_awaddr_i[31:5], axi_awaddr_i[1:0],
                           axi_araddr_i[31:5], axi_araddr_i[1:0],
                           strb_mask[31:DST_W]};

    always_comb begin
        status = '0;
        status[ST_RX_EMPTY] = rx_empty;
        status[ST_RX_FULL]  = rx_full;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_TX_FULL]  = tx_full;
        status[ST_RX_CNT_LSB +: 8] = sat_count8(32'(rx_count));
        status[ST_TX_CNT_LSB +: 8] = sat_count8(32'(tx_count));
    end

    // Ready is a registered one-cycle pulse; the handshake lands on the cycle it is high
    always_comb begin
        aw_rdy_d = axi_awvalid_i & axi_wvalid_i & ~bvalid_q & ~aw_rdy_q;
        ar_rdy_d = axi_arvalid_i & ~rvalid_q & ~ar_rdy_q;
        wr_fire  = aw_rdy_q & axi_awvalid_i & axi_wvalid_i;
        rd_fire  = ar_rdy_q & axi_arvalid_i;
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        ctrl_d   = ctrl_q;
        tx_hdr_d = tx_hdr_q;
        tx_push  = 1'b0;
        rx_pop   = 1'b0;

        if (bvalid_q && axi_bready_i) begin
            bvalid_d = 1'b0;
        end
        if (wr_fire) begin
            bvalid_d = 1'b1;
            bresp_d  = RESP_OKAY;
            case (reg_sel_e'(axi_awaddr_i[4:2]))
                REG_CTRL: begin
                    if (axi_wstrb_i[0]) ctrl_d = axi_wdata_i[1:0];
                end
                REG_TX_HDR: begin
                    tx_hdr_d = (tx_hdr_q & ~strb_mask[DST_W-1:0])
                             | (axi_wdata_i[DST_W-1:0] & strb_mask[DST_W-1:0]);
                end
                REG_TX_DATA: begin
                    if (tx_full || axi_wstrb_i != 4'hF) bresp_d = RESP_SLVERR;
                    else                                tx_push = 1'b1;
                end
                default: ;
            endcase
        end

        if (rvalid_q && axi_rready_i) begin
            rvalid_d = 1'b0;
        end
        if (rd_fire) begin
            rvalid_d = 1'b1;
            rresp_d  = RESP_OKAY;
            rdata_d  = '0;
            case (reg_sel_e'(axi_araddr_i[4:2]))
                REG_STATUS: rdata_d = status;
                REG_CTRL:   rdata_d = 32'(ctrl_q);
                REG_TX_HDR: rdata_d = 32'(tx_hdr_q);
                REG_RX_HDR: begin
                    if (!rx_empty) rdata_d = 32'(rx_head[BUS_W-1:DW]);
                end
                REG_RX_DATA: begin
                    if (rx_empty) begin
                        rresp_d = RESP_SLVERR;
                    end else begin
                        rdata_d = 32'(rx_head[DW-1:0]);
                        rx_pop  = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        irq_d = (ctrl_q[CTRL_RX_INT_EN] & ~rx_empty)
              | (ctrl_q[CTRL_TX_EMPTY_INT_EN] & tx_empty);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            aw_rdy_q <= 1'b0;
            ar_rdy_q <= 1'b0;
            bvalid_q <= 1'b0;
            bresp_q  <= '0;
            rvalid_q <= 1'b0;
            rresp_q  <= '0;
            rdata_q  <= '0;
            ctrl_q   <= '0;
            tx_hdr_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            aw_rdy_q <= aw_rdy_d;
            ar_rdy_q <= ar_rdy_d;
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
            rvalid_q <= rvalid_d;
            rresp_q  <= rresp_d;
            rdata_q  <= rdata_d;
            ctrl_q   <= ctrl_d;
            tx_hdr_q <= tx_hdr_d;
            irq_q    <= irq_d;
        end
    end

endmodule

// File: tb/tb_rtsnoc_axi4lite_fifo_slave.sv
// Directed + randomized bench for the RTSNoC AXI4-Lite FIFO slave, checked
// against queue-based TX/RX models and field arithmetic on the flit format.
module tb_rtsnoc_axi4lite_fifo_slave;

    localparam int NX = 1, NY = 0, NH = 5;
    localparam int BUS_W = 42;
    localparam int DEPTH = 4;
    localparam int TMO = 50;
    localparam int SRC_HDR = (NX * 2 + NY) * 8 + NH;

    localparam logic [31:0] A_STATUS = 32'h00, A_CTRL = 32'h04, A_TX_HDR = 32'h08;
    localparam logic [31:0] A_TX_DATA = 32'h0C, A_RX_HDR = 32'h10, A_RX_DATA = 32'h14;

    logic clk = 1'b0;
    logic rst_n;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  wstrb;
    logic awvalid, wvalid, bready, arvalid, rready;
    logic axi_awready_o, axi_wready_o, axi_bvalid_o, axi_arready_o, axi_rvalid_o;
    logic [1:0]  axi_bresp_o, axi_rresp_o;
    logic [31:0] axi_rdata_o;
    logic [BUS_W-1:0] noc_din_o, noc_dout_i;
    logic noc_wr_o, noc_wait_i, noc_nd_i, noc_rd_o, noc_int_o;

    int n_checks = 0;
    int n_fails  = 0;
    int rx_acc_n = 0;
    logic wr_after_accept;
    logic [BUS_W-1:0] tx_seen[$], tx_exp[$], rx_src[$], rx_exp[$];

    always #5 clk = ~clk;

    rtsnoc_axi4lite_fifo_slave #(
        .NOC_X(NX), .NOC_Y(NY), .NOC_LOCAL_ADR(NH),
        .SOC_SIZE_X(1), .SOC_SIZE_Y(1), .NOC_DATA_WIDTH(32),
        .TX_DEPTH_LOG2(2), .RX_DEPTH_LOG2(2)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .axi_awaddr_i(awaddr), .axi_awvalid_i(awvalid), .axi_awready_o(axi_awready_o),
        .axi_wdata_i(wdata), .axi_wstrb_i(wstrb), .axi_wvalid_i(wvalid), .axi_wready_o(axi_wready_o),
        .axi_bresp_o(axi_bresp_o), .axi_bvalid_o(axi_bvalid_o), .axi_bready_i(bready),
        .axi_araddr_i(araddr), .axi_arvalid_i(arvalid), .axi_arready_o(axi_arready_o),
        .axi_rdata_o(axi_rdata_o), .axi_rresp_o(axi_rresp_o), .axi_rvalid_o(axi_rvalid_o),
        .axi_rready_i(rready),
        .noc_din_o(noc_din_o), .noc_wr_o(noc_wr_o), .noc_wait_i(noc_wait_i),
        .noc_dout_i(noc_dout_i), .noc_nd_i(noc_nd_i), .noc_rd_o(noc_rd_o), .noc_int_o(noc_int_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BUS_W-1:0] tx_flit(input logic [4:0] h, input logic [31:0] d);
        logic [63:0] v;
        v = (64'(SRC_HDR * 32 + int'(h)) << 32) + 64'(d);
        return v[BUS_W-1:0];
    endfunction

    function automatic logic [31:0] st_exp(input int rxn, input int txn);
        return 32'((rxn == 0 ? 1 : 0) + (rxn == DEPTH ? 2 : 0) + (txn == 0 ? 4 : 0)
                 + (txn == DEPTH ? 8 : 0) + rxn * 256 + txn * 65536);
    endfunction

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        int t = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        while (!(axi_awready_o && axi_wready_o) && t < TMO) begin @(posedge clk); #1; t++; end
        chk("aw_handshake_timeout", 64'(t < TMO), 64'd1);
        @(posedge clk); #1;
        wr_after_accept = noc_wr_o;
        awvalid = 1'b0; wvalid = 1'b0;
        t = 0;
        while (!axi_bvalid_o && t < TMO) begin @(posedge clk); #1; t++; end
        chk("b_timeout", 64'(t < TMO), 64'd1);
        resp = axi_bresp_o;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        int t = 0;
        araddr = a; arvalid = 1'b1;
        while (!axi_arready_o && t < TMO) begin @(posedge clk); #1; t++; end
        chk("ar_handshake_timeout", 64'(t < TMO), 64'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        t = 0;
        while (!axi_rvalid_o && t < TMO) begin @(posedge clk); #1; t++; end
        chk("r_timeout", 64'(t < TMO), 64'd1);
        d = axi_rdata_o; resp = axi_rresp_o;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] ed,
                          input logic [1:0] er);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(a, d, r);
        chk({tag, "_data"}, 64'(d), 64'(ed));
        chk({tag, "_resp"}, 64'(r), 64'(er));
    endtask

    task automatic cmp_tx(input string tag);
        chk({tag, "_flit_count"}, 64'(tx_seen.size()), 64'(tx_exp.size()));
        while (tx_seen.size() != 0 && tx_exp.size() != 0)
            chk({tag, "_flit"}, 64'(tx_seen.pop_front()), 64'(tx_exp.pop_front()));
        tx_seen.delete(); tx_exp.delete();
    endtask

    initial begin
        logic [1:0]  r;
        logic [4:0]  h;
        logic [31:0] d;
        logic [BUS_W-1:0] f;
        int t, base, op;

        rst_n = 1'b0;
        awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        noc_wait_i = 1'b0; noc_nd_i = 1'b0; noc_dout_i = '0;

        fork
            forever begin
                @(negedge clk);
                if (noc_wr_o === 1'b1 && !noc_wait_i) tx_seen.push_back(noc_din_o);
            end
            forever begin
                logic took;
                @(negedge clk);
                took = (noc_rd_o === 1'b1);
                if (took) rx_acc_n++;
                @(posedge clk); #1;
                if (took && rx_src.size() != 0) void'(rx_src.pop_front());
                noc_nd_i   = (rx_src.size() != 0);
                noc_dout_i = (rx_src.size() != 0) ? rx_src[0] : '0;
            end
        join_none

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: reset in the middle of a write
        awaddr = A_TX_DATA; wdata = 32'h1234_5678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1;
        chk("pre_reset_awready", 64'(axi_awready_o), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("reset_outputs", 64'({axi_awready_o, axi_wready_o, axi_bvalid_o, axi_bresp_o,
                                  axi_arready_o, axi_rvalid_o, axi_rresp_o, axi_rdata_o,
                                  noc_wr_o, noc_rd_o, noc_int_o}), 64'd0);
        awvalid = 1'b0; wvalid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        rd_chk("reset_status", A_STATUS, 32'h5, 2'b00);
        rd_chk("reset_ctrl", A_CTRL, 32'h0, 2'b00);
        rd_chk("reset_txhdr", A_TX_HDR, 32'h0, 2'b00);

        // 2: single TX flit
        axi_write(A_TX_HDR, 32'h13, 4'hF, r);
        chk("txhdr_wr_resp", 64'(r), 64'd0);
        axi_write(A_TX_HDR, 32'hFFFF_FF00, 4'hE, r);
        rd_chk("txhdr_strobe", A_TX_HDR, 32'h13, 2'b00);
        axi_write(A_TX_DATA, 32'hCAFE_BABE, 4'hF, r);
        chk("tx_wr_resp", 64'(r), 64'd0);
        chk("tx_wr_latency", 64'(wr_after_accept), 64'd1);
        tx_exp.push_back(tx_flit(5'h13, 32'hCAFE_BABE));
        repeat (4) @(posedge clk); #1;
        chk("tx_idle", 64'(noc_wr_o), 64'd0);
        cmp_tx("tx_single");
        rd_chk("tx_status", A_STATUS, st_exp(0, 0), 2'b00);

        // 3: backpressure, depth overflow, bad strobe
        noc_wait_i = 1'b1;
        h = 5'($urandom);
        axi_write(A_TX_HDR, 32'(h), 4'hF, r);
        axi_write(A_TX_DATA, $urandom, 4'h7, r);
        chk("tx_bad_strb_resp", 64'(r), 64'd2);
        for (int i = 0; i < 5; i++) begin
            d = $urandom;
            axi_write(A_TX_DATA, d, 4'hF, r);
            chk("tx_fill_resp", 64'(r), (tx_exp.size() < DEPTH) ? 64'd0 : 64'd2);
            if (tx_exp.size() < DEPTH) tx_exp.push_back(tx_flit(h, d));
        end
        rd_chk("tx_full_status", A_STATUS, st_exp(0, DEPTH), 2'b00);
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            noc_wait_i = 1'($urandom);
        end
        noc_wait_i = 1'b0;
        repeat (4) @(posedge clk); #1;
        cmp_tx("tx_backpressure");

        // 3b: random register traffic with the router draining freely
        for (int i = 0; i < 16; i++) begin
            op = int'($urandom_range(3, 0));
            d = $urandom;
            case (op)
                0: begin
                    h = 5'($urandom);
                    axi_write(A_TX_HDR, 32'(h), 4'hF, r);
                    chk("rand_hdr_resp", 64'(r), 64'd0);
                end
                1: begin
                    axi_write(A_TX_DATA, d, 4'hF, r);
                    chk("rand_data_resp", 64'(r), 64'd0);
                    tx_exp.push_back(tx_flit(h, d));
                end
                2: begin
                    axi_write(A_TX_DATA, d, 4'($urandom_range(14, 0)), r);
                    chk("rand_strb_resp", 64'(r), 64'd2);
                end
                default: begin
                    axi_write(32'h18, d, 4'hF, r);
                    chk("unmapped_wr_resp", 64'(r), 64'd0);
                    rd_chk("unmapped_rd", 32'h1C, 32'h0, 2'b00);
                end
            endcase
        end
        repeat (4) @(posedge clk); #1;
        cmp_tx("tx_random");

        // 4: RX basic
        rx_exp.push_back(BUS_W'((64'($urandom_range(1023, 0)) << 32) + 64'h11));
        rx_exp.push_back(BUS_W'((64'($urandom_range(1023, 0)) << 32) + 64'h22));
        rx_src.push_back(rx_exp[0]);
        rx_src.push_back(rx_exp[1]);
        repeat (6) @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            f = rx_exp.pop_front();
            rd_chk("rx_hdr", A_RX_HDR, 32'(f >> 32), 2'b00);
            rd_chk("rx_data", A_RX_DATA, f[31:0], 2'b00);
        end
        rd_chk("rx_empty_data", A_RX_DATA, 32'h0, 2'b10);
        rd_chk("rx_empty_hdr", A_RX_HDR, 32'h0, 2'b00);

        // 5: RX full backpressure
        base = rx_acc_n;
        for (int i = 0; i < 6; i++) begin
            f = BUS_W'({$urandom, $urandom});
            rx_exp.push_back(f);
            rx_src.push_back(f);
        end
        repeat (12) @(posedge clk); #1;
        chk("rx_accepted_at_full", 64'(rx_acc_n - base), 64'd4);
        chk("rx_rd_stalled", 64'(noc_rd_o), 64'd0);
        rd_chk("rx_full_status", A_STATUS, st_exp(DEPTH, 0), 2'b00);
        f = rx_exp.pop_front();
        rd_chk("rx_full_pop", A_RX_DATA, f[31:0], 2'b00);
        repeat (4) @(posedge clk); #1;
        chk("rx_accepted_after_pop", 64'(rx_acc_n - base), 64'd5);
        while (rx_exp.size() != 0) begin
            f = rx_exp.pop_front();
            rd_chk("rx_drain", A_RX_DATA, f[31:0], 2'b00);
        end
        rd_chk("rx_drained_data", A_RX_DATA, 32'h0, 2'b10);
        chk("rx_total_accepted", 64'(rx_acc_n - base), 64'd6);

        // 6: interrupts
        axi_write(A_CTRL, 32'h1, 4'hF, r);
        repeat (2) @(posedge clk); #1;
        chk("irq_idle", 64'(noc_int_o), 64'd0);
        f = BUS_W'({$urandom, $urandom});
        rx_src.push_back(f);
        t = 0;
        do begin @(negedge clk); t++; end while (noc_rd_o !== 1'b1 && t < TMO);
        chk("irq_push_timeout", 64'(t < TMO), 64'd1);
        @(posedge clk); #1;
        chk("irq_at_push", 64'(noc_int_o), 64'd0);
        @(posedge clk); #1;
        chk("irq_after_push", 64'(noc_int_o), 64'd1);
        rd_chk("irq_pop", A_RX_DATA, f[31:0], 2'b00);
        repeat (2) @(posedge clk); #1;
        chk("irq_after_pop", 64'(noc_int_o), 64'd0);
        axi_write(A_CTRL, 32'h2, 4'hF, r);
        repeat (2) @(posedge clk); #1;
        chk("irq_tx_empty", 64'(noc_int_o), 64'd1);
        axi_write(A_CTRL, 32'h3, 4'hF, r);
        noc_wait_i = 1'b1;
        d = $urandom;
        axi_write(A_TX_DATA, d, 4'hF, r);
        tx_exp.push_back(tx_flit(h, d));
        repeat (2) @(posedge clk); #1;
        chk("irq_tx_pending", 64'(noc_int_o), 64'd0);
        noc_wait_i = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("irq_tx_drained", 64'(noc_int_o), 64'd1);
        cmp_tx("irq_tx");
        axi_write(A_CTRL, 32'h0, 4'hF, r);
        repeat (2) @(posedge clk); #1;
        chk("irq_disabled", 64'(noc_int_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
